// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access sequencer for a 16-bit asynchronous SRAM (optional read buffer: SRAM_READ_BUFFER_EN)
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Word index width: one address bit is spent on the half-word select.
    localparam int          IW        = SRAM_AW - 1;
    localparam logic [3:0]  LP_RELOAD = 4'(WAIT_CYCLES - 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_is_wr;
    logic [IW-1:0]   r_idx;
    logic [15:0]     r_low;
    logic [31:0]     r_read_data;
    logic [SRAM_AW-1:0] r_addr;
    logic [15:0]     r_dq_out;
    logic            r_dq_oe;
    logic            r_we_n;
    logic            r_oe_n;

    logic            w_req;
    logic [31:0]     w_offset;
    logic [IW-1:0]   w_word_idx;
    logic            w_last;

    assign w_req      = rd_en | wr_en;
    assign w_offset   = address - 32'(BASE_ADDR);
    // Byte offset to word index; the cast drops address[1:0] and wraps out-of-range words.
    assign w_word_idx = IW'(w_offset >> 2);
    assign w_last     = (r_cnt == 4'd0);

`ifdef SRAM_READ_BUFFER_EN
    logic            r_buf_valid;
    logic [IW-1:0]   r_buf_idx;
    logic [31:0]     r_buf_data;
    logic            w_hit;

    // A pure read (a simultaneous write wins) that matches the buffered word.
    assign w_hit = rd_en & ~wr_en & r_buf_valid & (r_buf_idx == w_word_idx);

    // Buffer fill on read completion; write-through update when a write hits the buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_idx   <= '0;
            r_buf_data  <= 32'h0;
        end else if (r_state == S_HIGH && w_last) begin
            if (!r_is_wr) begin
                r_buf_valid <= 1'b1;
                r_buf_idx   <= r_idx;
                r_buf_data  <= {sram_dq_in, r_low};
            end else if (r_buf_valid && r_buf_idx == r_idx) begin
                r_buf_data  <= write_data;
            end
        end
    end
`endif

    // Access sequencer: state, wait counter, read capture and registered SRAM pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_low       <= 16'h0;
            r_read_data <= 32'h0;
            r_addr      <= '0;
            r_dq_out    <= 16'h0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef SRAM_READ_BUFFER_EN
                    if (w_hit) begin
                        r_state     <= S_DONE;
                        r_read_data <= r_buf_data;
                    end else
`endif
                    if (w_req) begin
                        // Operation and word index are frozen here for the whole access.
                        r_state  <= S_LOW;
                        r_cnt    <= LP_RELOAD;
                        r_is_wr  <= wr_en;
                        r_idx    <= w_word_idx;
                        r_addr   <= {w_word_idx, 1'b0};
                        r_dq_out <= wr_en ? write_data[15:0] : 16'h0;
                        r_dq_oe  <= wr_en;
                        r_we_n   <= ~wr_en;
                        r_oe_n   <= wr_en;
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            r_low <= sram_dq_in;
                        end
                        r_state  <= S_HIGH;
                        r_cnt    <= LP_RELOAD;
                        r_addr   <= {r_idx, 1'b1};
                        r_dq_out <= r_is_wr ? write_data[31:16] : 16'h0;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                        r_dq_out <= r_is_wr ? write_data[15:0] : 16'h0;
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        // Both halves land in read_data together so it never shows a torn word.
                        if (!r_is_wr) begin
                            r_read_data <= {sram_dq_in, r_low};
                        end
                        r_state  <= S_DONE;
                        r_dq_out <= 16'h0;
                        r_dq_oe  <= 1'b0;
                        r_we_n   <= 1'b1;
                        r_oe_n   <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                        r_dq_out <= r_is_wr ? write_data[31:16] : 16'h0;
                    end
                end
                S_DONE: begin
                    // Never accept a request here; the requester sees ready=1 first.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze: low while a request waits in IDLE or a phase is running.
    always_comb begin
        ready = 1'b1;
        case (r_state)
            S_IDLE:  ready = ~w_req;
            S_LOW:   ready = 1'b0;
            S_HIGH:  ready = 1'b0;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed scoreboard bench for sram_controller
module tb_sram_controller;

    localparam int WAIT     = 2;
    localparam int FULL_LAT = 2 * WAIT + 1;
`ifdef SRAM_READ_BUFFER_EN
    localparam int HIT_LAT  = 1;
`else
    localparam int HIT_LAT  = FULL_LAT;
`endif

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:63];
    logic [31:0] ref_mem [int];
    logic [31:0] sb [$];
    logic [31:0] last_read;

    sram_controller #(
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (WAIT),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: seeded during reset, written while we_n is low.
    always @(posedge clk) begin
        if (rst) begin
            mem[2] <= 16'h1234;
            mem[3] <= 16'hABCD;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd_i, input logic wr_i, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat, input logic hold);
        logic [16:0] idx;
        logic        half;
        int          n;
        idx = 17'((addr - 32'd1024) >> 2);
        if (wr_i) ref_mem[int'(idx)] = wd;
        else      sb.push_back(ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'h0);
        rd_en = rd_i;
        wr_en = wr_i;
        address = addr;
        write_data = wd;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            if (n == 0) begin
                chk("req_we_n", 32'(sram_we_n), 32'd1);
                chk("req_oe_n", 32'(sram_oe_n), 32'd1);
            end else begin
                half = (n > WAIT);
                chk("ph_addr", 32'(sram_addr), 32'({idx, half}));
                chk("ph_we_n", 32'(sram_we_n), 32'(!wr_i));
                chk("ph_oe_n", 32'(sram_oe_n), 32'(wr_i));
                chk("ph_dq_oe", 32'(sram_dq_oe), 32'(wr_i));
                if (wr_i) chk("ph_dq", 32'(sram_dq_out), 32'(half ? wd[31:16] : wd[15:0]));
            end
            n++;
            if (n > 40) begin
                chk("timeout", 32'(n), 32'(exp_lat));
                break;
            end
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe_n", 32'(sram_oe_n), 32'd1);
        chk("done_dq_oe", 32'(sram_dq_oe), 32'd0);
        if (!wr_i) begin
            last_read = sb.pop_front();
            chk("rdata", read_data, last_read);
        end else begin
            chk("rdata_hold", read_data, last_read);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'h0;
        write_data = 32'h0;
        last_read = 32'h0;
        ref_mem[1] = 32'hABCD1234;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, FULL_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 1'b0);
        access(1'b0, 1'b1, 32'd1032, 32'h00000005, FULL_LAT, 1'b1);
        access(1'b1, 1'b0, 32'd1032, 32'h0, FULL_LAT, 1'b0);
        access(1'b1, 1'b1, 32'd1036, 32'h11112222, FULL_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1036, 32'h0, FULL_LAT, 1'b0);

        wr_en = 1'b1;
        address = 32'd1040;
        write_data = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        chk("mid_high_we_n", 32'(sram_we_n), 32'd0);
        chk("mid_high_addr", 32'(sram_addr), 32'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_rdata", read_data, 32'h0);
        last_read = 32'h0;
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, HIT_LAT, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h00000077, FULL_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, HIT_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1030, 32'h0, HIT_LAT, 1'b0);
        access(1'b1, 1'b0, 32'd1024 + (32'd1 << 19) + 32'd4, 32'h0, HIT_LAT, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
